// File: rtl/irrigation_timer_sequencer_pkg.sv
// Shared definitions for the irrigation timer sequencer.
//   - FSM state encoding (2 bits)
//   - bit offsets of the BCD digit fields inside preset/remaining
//   - default maximum value of each BCD digit
//   - clamp helper used when a preset is loaded
package irrigation_timer_sequencer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_PAUSED = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  // preset/remaining packing: {min_tens[1:0], min_units[3:0], sec_tens[3:0], sec_units[3:0]}
  localparam int SEC_UNITS_LSB = 0;
  localparam int SEC_TENS_LSB  = 4;
  localparam int MIN_UNITS_LSB = 8;
  localparam int MIN_TENS_LSB  = 12;

  localparam int MIN_TENS_MAX_DEF = 3;
  localparam int SEC_TENS_MAX_DEF = 5;
  localparam int UNITS_MAX_DEF    = 9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/irrigation_timer_sequencer_bcd_down_digit.sv
// One BCD down-counting digit with borrow output.
// Ports:
//   clock      - system clock
//   reset      - asynchronous active-low reset, clears q
//   load       - synchronous load of load_val (wins over dec_en)
//   load_val   - value to load
//   dec_en     - decrement request for this digit
//   q          - current digit value
//   borrow_out - decrement requested while q == 0 (digit wraps to MAX)
module bcd_down_digit #(
  parameter int MAX   = 9,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec_en,
  output logic [WIDTH-1:0] q,
  output logic             borrow_out
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec_en) begin
      q <= (q == '0) ? WIDTH'(MAX) : q - 1'b1;
    end
  end

  assign borrow_out = dec_en & (q == '0);

endmodule

// File: rtl/irrigation_timer_sequencer.sv
// Irrigation watering timer sequencer: loads an mm:ss preset into a cascaded
// BCD down-counter and counts it down once per 1 Hz tick, driving the valve
// while running and pulsing done on completion.
// Ports:
//   clock     - system clock
//   reset     - asynchronous active-low reset
//   tick      - one-cycle 1 Hz enable
//   start     - level, acts on its rising edge (IDLE/DONE only)
//   pause     - level, holds the countdown
//   stop      - level, aborts to IDLE and clears remaining
//   preset    - {min_tens[1:0], min_units, sec_tens, sec_units}
//   remaining - current time, same packing as preset
//   valve_on  - high in RUN and PAUSED
//   running   - high in RUN
//   done      - one-cycle completion pulse
//   warn      - (only with IRRIGATION_TIMER_WARN_EN) RUN/PAUSED with remaining <= 00:10
//
// State table:
//   state     | meaning
//   ST_IDLE   | waiting for start, remaining = 0
//   ST_RUN    | valve open, counting down on tick
//   ST_PAUSED | valve open, countdown frozen
//   ST_DONE   | countdown finished, remaining = 0
module irrigation_timer_sequencer
  import irrigation_timer_sequencer_pkg::*;
#(
  parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF,
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int UNITS_MAX    = UNITS_MAX_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic [13:0] preset,
`ifdef IRRIGATION_TIMER_WARN_EN
  output logic        warn,
`endif
  output logic [13:0] remaining,
  output logic        valve_on,
  output logic        running,
  output logic        done
);

  logic [1:0]  state, state_nxt;
  logic        start_q, start_edge;
  logic        can_load, digit_load, final_tick, preset_zero, done_nxt;
  logic        dec_su, b_su, b_st, b_mu, b_mt;
  logic [1:0]  p_mt, q_mt;
  logic [3:0]  q_mu, q_st, q_su;
  logic [13:0] preset_clamped, load_val;

  assign start_edge = start & ~start_q;
  assign can_load   = start_edge & ((state == ST_IDLE) | (state == ST_DONE));

  assign p_mt = (preset[MIN_TENS_LSB +: 2] > 2'(MIN_TENS_MAX)) ? 2'(MIN_TENS_MAX)
                                                                : preset[MIN_TENS_LSB +: 2];
  assign preset_clamped = {p_mt,
                           clamp_digit(preset[MIN_UNITS_LSB +: 4], 4'(UNITS_MAX)),
                           clamp_digit(preset[SEC_TENS_LSB +: 4], 4'(SEC_TENS_MAX)),
                           clamp_digit(preset[SEC_UNITS_LSB +: 4], 4'(UNITS_MAX))};
  assign preset_zero = (preset_clamped == '0);

  assign remaining = {q_mt, q_mu, q_st, q_su};

  // A tick in RUN always decrements unless pause or stop take precedence.
  assign dec_su     = ~stop & (state == ST_RUN) & ~pause & tick;
  assign final_tick = dec_su & (remaining == 14'd1);

  // A borrow out of the top digit can only come from decrementing 00:00;
  // reloading zero pins the counter there instead of wrapping to 39:59.
  assign digit_load = stop | can_load | b_mt;
  assign load_val   = (stop | b_mt) ? '0 : preset_clamped;

  bcd_down_digit #(.MAX(UNITS_MAX), .WIDTH(4)) u_sec_units (
    .clock(clock), .reset(reset), .load(digit_load), .load_val(load_val[SEC_UNITS_LSB +: 4]),
    .dec_en(dec_su), .q(q_su), .borrow_out(b_su));
  bcd_down_digit #(.MAX(SEC_TENS_MAX), .WIDTH(4)) u_sec_tens (
    .clock(clock), .reset(reset), .load(digit_load), .load_val(load_val[SEC_TENS_LSB +: 4]),
    .dec_en(b_su), .q(q_st), .borrow_out(b_st));
  bcd_down_digit #(.MAX(UNITS_MAX), .WIDTH(4)) u_min_units (
    .clock(clock), .reset(reset), .load(digit_load), .load_val(load_val[MIN_UNITS_LSB +: 4]),
    .dec_en(b_st), .q(q_mu), .borrow_out(b_mu));
  bcd_down_digit #(.MAX(MIN_TENS_MAX), .WIDTH(2)) u_min_tens (
    .clock(clock), .reset(reset), .load(digit_load), .load_val(load_val[MIN_TENS_LSB +: 2]),
    .dec_en(b_mu), .q(q_mt), .borrow_out(b_mt));

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (can_load) begin
      state_nxt = preset_zero ? ST_DONE : ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause)           state_nxt = ST_PAUSED;
          else if (final_tick) state_nxt = ST_DONE;
        end
        ST_PAUSED: begin
          if (!pause) state_nxt = ST_RUN;
        end
        default: state_nxt = state;
      endcase
    end
  end

  assign done_nxt = ~stop & ((can_load & preset_zero) | final_tick);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      valve_on <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_q  <= start;
      valve_on <= (state_nxt == ST_RUN) | (state_nxt == ST_PAUSED);
      running  <= (state_nxt == ST_RUN);
      done     <= done_nxt;
    end
  end

`ifdef IRRIGATION_TIMER_WARN_EN
  // Seconds-only compare in BCD: min digits zero and secs <= limit (10 or 11).
  function automatic logic secs_le(input logic [13:0] t, input logic [3:0] unit_lim);
    return (t[13:8] == '0) &&
           ((t[7:4] == 4'd0) || ((t[7:4] == 4'd1) && (t[3:0] <= unit_lim)));
  endfunction

  logic warn_nxt, warn_val;

  // Predict the value remaining takes on this edge so warn lines up with it.
  always_comb begin
    if (can_load)    warn_val = secs_le(preset_clamped, 4'd0);
    else if (dec_su) warn_val = secs_le(remaining, 4'd1);
    else             warn_val = secs_le(remaining, 4'd0);
  end

  assign warn_nxt = ((state_nxt == ST_RUN) | (state_nxt == ST_PAUSED)) & warn_val;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) warn <= 1'b0;
    else        warn <= warn_nxt;
  end
`endif

endmodule

// File: tb/tb_irrigation_timer_sequencer.sv
module tb_irrigation_timer_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop  = 1'b0;
  logic [13:0] preset = '0;
  logic [13:0] remaining;
  logic        valve_on, running, done;
`ifdef IRRIGATION_TIMER_WARN_EN
  logic        warn;
`endif

  int total = 0;
  int bad   = 0;

  irrigation_timer_sequencer dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .stop(stop), .preset(preset),
`ifdef IRRIGATION_TIMER_WARN_EN
    .warn(warn),
`endif
    .remaining(remaining), .valve_on(valve_on), .running(running), .done(done));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic load_go(input logic [13:0] p);
    preset = p;
    start  = 1'b1;
    cyc();
    start  = 1'b0;
  endtask

  task automatic tick1();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic abort();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_rem",   32'(remaining), 32'h0);
    chk("rst_valve", 32'(valve_on),  32'h0);
    chk("rst_run",   32'(running),   32'h0);
    chk("rst_done",  32'(done),      32'h0);
    #10 reset = 1'b1;
    cyc();

    // 00:03 down to completion
    load_go(14'h0003);
    chk("t1_valve", 32'(valve_on),  32'h1);
    chk("t1_run",   32'(running),   32'h1);
    chk("t1_rem3",  32'(remaining), 32'h0003);
    tick1(); chk("t1_rem2", 32'(remaining), 32'h0002);
    chk("t1_nodone", 32'(done), 32'h0);
    tick1(); chk("t1_rem1", 32'(remaining), 32'h0001);
    tick1();
    chk("t1_rem0",   32'(remaining), 32'h0000);
    chk("t1_done",   32'(done),      32'h1);
    chk("t1_valve0", 32'(valve_on),  32'h0);
    chk("t1_run0",   32'(running),   32'h0);
    cyc();
    chk("t1_done0",  32'(done),      32'h0);
    chk("t1_hold0",  32'(remaining), 32'h0000);

    // 10:00 -> 09:59, start edge in RUN ignored
    load_go(14'h1000);
    chk("t2_load", 32'(remaining), 32'h1000);
    tick1();
    chk("t2_rem",   32'(remaining), 32'h0959);
    chk("t2_valve", 32'(valve_on),  32'h1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t2_noreload", 32'(remaining), 32'h0959);
    chk("t2_stillrun", 32'(running),   32'h1);
    abort();

    // pause freezes ticks
    load_go(14'h0005);
    tick1(); tick1();
    chk("t3_rem3", 32'(remaining), 32'h0003);
    pause = 1'b1; cyc();
    chk("t3_paused_run", 32'(running),  32'h0);
    chk("t3_paused_vlv", 32'(valve_on), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick1();
      chk("t3_frozen", 32'(remaining), 32'h0003);
      chk("t3_vlv",    32'(valve_on),  32'h1);
    end
    pause = 1'b0; cyc();
    chk("t3_resume", 32'(running), 32'h1);
    tick1();
    chk("t3_rem2",  32'(remaining), 32'h0002);
    chk("t3_vlv2",  32'(valve_on),  32'h1);
    abort();

    // tick and pause together: pause wins
    load_go(14'h0004);
    tick = 1'b1; pause = 1'b1; cyc(); tick = 1'b0;
    chk("t4_rem",   32'(remaining), 32'h0004);
    chk("t4_run",   32'(running),   32'h0);
    chk("t4_valve", 32'(valve_on),  32'h1);
    pause = 1'b0; cyc();
    abort();

    // stop in RUN at 02:30
    load_go(14'h0230);
    chk("t4_load", 32'(remaining), 32'h0230);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("t4s_rem",   32'(remaining), 32'h0);
    chk("t4s_valve", 32'(valve_on),  32'h0);
    chk("t4s_run",   32'(running),   32'h0);
    chk("t4s_done",  32'(done),      32'h0);
    cyc();
    chk("t4s_done2", 32'(done),      32'h0);

    // zero preset goes straight to DONE
    load_go(14'h0000);
    chk("t5_rem",   32'(remaining), 32'h0);
    chk("t5_valve", 32'(valve_on),  32'h0);
    chk("t5_done",  32'(done),      32'h1);
    cyc();
    chk("t5_done0",  32'(done),     32'h0);
    chk("t5_valve0", 32'(valve_on), 32'h0);

    // clamping
    load_go(14'h1299);
    chk("t5_clamp1", 32'(remaining), 32'h1259);
    abort();
    load_go(14'h3AF7);
    chk("t5_clamp2", 32'(remaining), 32'h3957);
    abort();

    // 00:10 -> 00:09
    load_go(14'h0010);
    tick1();
    chk("t5_borrow", 32'(remaining), 32'h0009);
    abort();

    // async reset mid-RUN
    load_go(14'h0517);
    #3 reset = 1'b0;
    #1;
    chk("t6_rem",   32'(remaining), 32'h0);
    chk("t6_valve", 32'(valve_on),  32'h0);
    chk("t6_run",   32'(running),   32'h0);
    chk("t6_done",  32'(done),      32'h0);
    #1 reset = 1'b1;
    cyc();
    tick1();
    chk("t6_idle_rem",  32'(remaining), 32'h0);
    chk("t6_idle_done", 32'(done),      32'h0);

`ifdef IRRIGATION_TIMER_WARN_EN
    load_go(14'h0012);
    chk("w_off12", 32'(warn), 32'h0);
    tick1(); chk("w_off11", 32'(warn), 32'h0);
    tick1(); chk("w_on10",  32'(warn), 32'h1);
    for (int i = 0; i < 9; i++) tick1();
    chk("w_rem1", 32'(remaining), 32'h0001);
    chk("w_on1",  32'(warn),      32'h1);
    tick1();
    chk("w_done",    32'(done), 32'h1);
    chk("w_offdone", 32'(warn), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irrigation_timer_sequencer.md
Name: irrigation_timer_sequencer

Overview:
Sequencer for the irrigation watering timer. Loads an mm:ss preset into a cascaded BCD down-counter chain and decrements it once per 1 Hz tick. Drives the valve enable while running and flags completion. Sits between the front-panel control logic and the valve driver; the minutes-tens digit is a mod-4 (0..3) down digit.

Parameters:
MIN_TENS_MAX, 3, highest minutes-tens value (digit range 0..MIN_TENS_MAX)
SEC_TENS_MAX, 5, highest seconds-tens value
UNITS_MAX, 9, highest value of either units digit

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; low forces IDLE immediately
tick  input  1  one-cycle 1 Hz enable, synchronous to clock
start  input  1  level; sampled each cycle, acts on rising edge only
pause  input  1  level; high holds the countdown
stop  input  1  level; aborts to IDLE
preset  input  14  {min_tens[1:0], min_units[3:0], sec_tens[3:0], sec_units[3:0]}
remaining  output  14  current time, same packing as preset
valve_on  output  1  high only in RUN and PAUSED
running  output  1  high only in RUN
done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (reset low, async): state IDLE, remaining = 0, valve_on = 0, running = 0, done = 0, start-edge register = 0.
- States: IDLE, RUN, PAUSED, DONE. Encoding: 2 bits, IDLE = 00, RUN = 01, PAUSED = 10, DONE = 11.
- Per-cycle priority: stop > start edge > pause > tick.
- stop high in any state -> IDLE next cycle; remaining cleared to 0; no done pulse.
- start rising edge in IDLE or DONE: remaining <= clamped preset on the same edge.
  - Preset non-zero -> RUN.
  - Preset zero -> DONE, with done pulsed in the next cycle.
- start edge in RUN or PAUSED: ignored; no reload.
- Clamping: any preset digit above its MAX loads as MAX, e.g. sec_tens = 7 loads as 5.
- RUN, pause high -> PAUSED. A tick in that same cycle is discarded.
- PAUSED, pause low -> RUN. Ticks while PAUSED are discarded; remaining is frozen.
- RUN, tick high, remaining != 0: BCD decrement with borrow chain sec_units -> sec_tens -> min_units -> min_tens.
  - Each digit wraps to its MAX on borrow. Example: 10:00 -> 09:59.
- RUN, tick brings remaining to 00:00 -> DONE on that edge; done = 1 for exactly the following cycle. valve_on drops on the same edge.
- Latency: start edge to valve_on = 1 clock. Final tick to done = 1 clock.
- DONE holds remaining = 0 until start or stop. Stop from DONE -> IDLE.
- Async reset mid-RUN: immediate IDLE with all outputs 0; no done pulse.
- Outputs are registered; no combinational input-to-output path.

Optional Feature:
Macro IRRIGATION_TIMER_WARN_EN.
- Defined: adds output port warn (1 bit).
  - Registered high while in RUN or PAUSED with remaining <= 00:10.
  - Low in every other case, including reset.
- Undefined: no warn port and no comparator logic; all other behaviour identical.

Decomposition:
- Shared include file: state encoding localparams (ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE), the preset field offsets, and the digit MAX defaults.
- One sub-module, bcd_down_digit:
  - Parameters: MAX and width.
  - Ports: clock, reset, load, load_val, dec_en, q, borrow_out.
  - borrow_out = dec_en & (q == 0).
- The sequencer instantiates four bcd_down_digit instances and the state register.

Test Plan:
- preset 00:03, start edge, 3 ticks -> valve_on high 1 cycle after start; remaining 00:02, 00:01, 00:00; done pulses once 1 cycle after the third tick; state DONE.
- preset 10:00, start, 1 tick -> remaining 09:59, valve_on stays 1.
- preset 00:05, start, 2 ticks, pause high for 4 ticks, then low, then 1 tick -> remaining 00:03 during pause, 00:02 after; valve_on high throughout.
- Tick and pause asserted in the same cycle while in RUN at 00:04 -> PAUSED, remaining still 00:04. Stop in RUN at 02:30 -> IDLE, remaining 0, valve_on 0, no done.
- preset 00:00, start -> DONE, done pulse, valve_on never asserts. Preset with sec_tens = 9 and units = 9 -> loads x:59.
- Reset low mid-RUN at 05:17 -> all outputs 0 immediately. With IRRIGATION_TIMER_WARN_EN: warn asserts at 00:10 and clears on entry to DONE.
